// File: rtl/sample_fifo_sync_pkg.sv
// Shared definitions for the compressed-sample FIFO: default geometry,
// the sample word type and the ID/value field layout.
package sample_fifo_sync_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF  = 13;
    localparam int COUNT_WIDTH_DEF = 16;

    // Field positions inside a sample word: unit ID on top, value below.
    localparam int ID_MSB    = 15;
    localparam int ID_LSB    = 13;
    localparam int VALUE_MSB = 12;
    localparam int VALUE_LSB = 0;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    // Packs a unit ID and a 13-bit value into one sample word.
    function automatic sample_t make_sample(input logic [ID_MSB-ID_LSB:0] id,
                                           input logic [VALUE_MSB-VALUE_LSB:0] value);
        sample_t s;
        s = '0;
        s[ID_MSB:ID_LSB]       = id;
        s[VALUE_MSB:VALUE_LSB] = value;
        return s;
    endfunction

endpackage

// File: rtl/sample_fifo_sync_if.sv
// Write/read bus of the sample FIFO. The FIFO side uses the slave modport,
// the collector/host side uses the master modport.
//
// Handshake: at a rising edge a write is accepted when wr_en is high and
// full is low; a read is accepted when rd_en is high and empty is low. The
// flags seen before the edge decide acceptance. There is no back-pressure
// beyond the flags: a request against a full/empty FIFO is simply dropped
// and reported one cycle later on overflow/underflow. wr_ack and valid are
// one-cycle strobes for the accepted operation of the previous edge.
interface sample_fifo_sync_if
    import sample_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0]  din;
    logic                   wr_en;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   full;
    logic                   almost_full;
    logic                   wr_ack;
    logic                   overflow;
    logic                   underflow;
    logic                   empty;
    logic                   almost_empty;
    logic                   valid;
    logic [COUNT_WIDTH-1:0] data_count;

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, almost_full, wr_ack, overflow, underflow,
               empty, almost_empty, valid, data_count
    );

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, almost_full, wr_ack, overflow, underflow,
               empty, almost_empty, valid, data_count
    );
endinterface

// File: rtl/sample_fifo_sync_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// The read register only loads on an accepted read, so it doubles as the
// FIFO's dout holding register.
module sample_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port: array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between accepted reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sample_fifo_sync.sv
// Single-clock standard-read FIFO for compressed samples. Pointers, the
// occupancy counter and the status strobes live here; storage is in
// sample_fifo_ram. Flags are decoded from the registered counter only.
module sample_fifo_sync
    import sample_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sample_fifo_sync_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = DEPTH_CNT - ONE_CNT;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  full_i;
    logic                  empty_i;

    // Flag decode from the registered count.
    assign full_i             = (count == DEPTH_CNT);
    assign empty_i            = (count == '0);
    assign bus.full           = full_i;
    assign bus.empty          = empty_i;
    assign bus.almost_full    = (count >= AFULL_CNT);
    assign bus.almost_empty   = (count <= ONE_CNT);
    assign bus.data_count     = COUNT_WIDTH'(count);

    // Acceptance uses the flags as they stand before the edge, so a full
    // FIFO can still read and an empty one can still write in the same cycle.
    assign wr_acc = bus.wr_en && !full_i;
    assign rd_acc = bus.rd_en && !empty_i;

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // One-cycle status strobes describing the previous edge's requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wr_ack    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.valid     <= 1'b0;
        end else begin
            bus.wr_ack    <= wr_acc;
            bus.overflow  <= bus.wr_en && full_i;
            bus.underflow <= bus.rd_en && empty_i;
            bus.valid     <= rd_acc;
        end
    end

    sample_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (bus.din),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (bus.dout)
    );
endmodule

// File: tb/tb_sample_fifo_sync.sv
// Directed bench for sample_fifo_sync: reset, ordering, full/empty edges,
// simultaneous read/write and pointer wrap-around.
module tb_sample_fifo_sync;
    import sample_fifo_sync_pkg::*;

    localparam int DEPTH = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sample_fifo_sync_if bus ();

    sample_fifo_sync dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] exp_q[$];
    int          exp_count;
    logic [15:0] exp_dout;
    logic        exp_wr_ack, exp_ovf, exp_udf, exp_valid;

    task automatic model_reset();
        exp_q.delete();
        exp_count  = 0;
        exp_dout   = '0;
        exp_wr_ack = 1'b0;
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;
        exp_valid  = 1'b0;
    endtask

    // Drives one clock of requests and advances the reference model.
    task automatic do_cycle(input logic w, input logic r, input logic [15:0] d);
        logic wa, ra;
        bus.din   = d;
        bus.wr_en = w;
        bus.rd_en = r;
        wa = w && (exp_count != DEPTH);
        ra = r && (exp_count != 0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        exp_wr_ack = wa;
        exp_ovf    = w && !wa;
        exp_udf    = r && !ra;
        exp_valid  = ra;
        if (ra) exp_dout = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        exp_count = exp_count + int'(wa) - int'(ra);
    endtask

    task automatic test_reset();
        do_cycle(1'b1, 1'b0, 16'h1234);
        do_cycle(1'b1, 1'b0, 16'h5678);
        do_cycle(1'b0, 1'b1, 16'h0000);
        checks++;
        if (bus.dout !== 16'h1234 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read dout=%h valid=%b want 1234/1", bus.dout, bus.valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.full, bus.almost_full, bus.empty, bus.almost_empty} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_flags f/af/e/ae=%b want 0011",
                     {bus.full, bus.almost_full, bus.empty, bus.almost_empty});
        end
        checks++;
        if (bus.data_count !== 16'd0 || bus.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count_dout count=%0d dout=%h want 0/0000", bus.data_count, bus.dout);
        end
        checks++;
        if ({bus.wr_ack, bus.overflow, bus.underflow, bus.valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes ack/ovf/udf/val=%b want 0000",
                     {bus.wr_ack, bus.overflow, bus.underflow, bus.valid});
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        do_cycle(1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.empty !== 1'b1 || bus.data_count !== 16'd0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL post_release empty=%b count=%0d valid=%b want 1/0/0",
                     bus.empty, bus.data_count, bus.valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] words [3];
        words[0] = make_sample(3'd1, 13'd1);
        words[1] = make_sample(3'd2, 13'd2);
        words[2] = make_sample(3'd3, 13'd3);
        checks++;
        if (words[0] !== 16'h2001 || words[2] !== 16'h6003) begin
            errors++;
            $display("FAIL sample_pack w0=%h w2=%h want 2001/6003", words[0], words[2]);
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0, words[i]);
            checks++;
            if (bus.wr_ack !== 1'b1 || bus.data_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL basic_write%0d ack=%b count=%0d want 1/%0d", i, bus.wr_ack, bus.data_count, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b1, 16'h0000);
            checks++;
            if (bus.dout !== words[i] || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL basic_read%0d dout=%h valid=%b want %h/1", i, bus.dout, bus.valid, words[i]);
            end
            checks++;
            if (bus.data_count !== 16'(2 - i) || bus.almost_empty !== ((2 - i) <= 1)) begin
                errors++;
                $display("FAIL basic_count%0d count=%0d ae=%b want %0d/%b",
                         i, bus.data_count, bus.almost_empty, 2 - i, (2 - i) <= 1);
            end
        end
        do_cycle(1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.valid !== 1'b0 || bus.dout !== 16'h6003 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle valid=%b dout=%h empty=%b want 0/6003/1", bus.valid, bus.dout, bus.empty);
        end
    endtask

    task automatic test_underflow();
        do_cycle(1'b0, 1'b1, 16'h0000);
        checks++;
        if ({bus.underflow, bus.valid} !== 2'b10 || bus.dout !== 16'h6003 || bus.data_count !== 16'd0) begin
            errors++;
            $display("FAIL underflow udf/val=%b dout=%h count=%0d want 10/6003/0",
                     {bus.underflow, bus.valid}, bus.dout, bus.data_count);
        end
        do_cycle(1'b1, 1'b1, 16'h7abc);
        checks++;
        if ({bus.wr_ack, bus.underflow, bus.valid} !== 3'b110 || bus.data_count !== 16'd1 ||
            bus.dout !== 16'h6003) begin
            errors++;
            $display("FAIL rw_empty ack/udf/val=%b count=%0d dout=%h want 110/1/6003",
                     {bus.wr_ack, bus.underflow, bus.valid}, bus.data_count, bus.dout);
        end
        do_cycle(1'b0, 1'b1, 16'h0000);
        checks++;
        if (bus.dout !== 16'h7abc || bus.valid !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rw_empty_drain dout=%h valid=%b empty=%b want 7abc/1/1", bus.dout, bus.valid, bus.empty);
        end
    endtask

    task automatic test_simul_mid();
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, make_sample(3'(i), 13'(100 + i)));
        end
        do_cycle(1'b1, 1'b1, 16'hbeef);
        checks++;
        if (bus.data_count !== 16'd5 || {bus.wr_ack, bus.valid} !== 2'b11 || bus.dout !== 16'h0064) begin
            errors++;
            $display("FAIL rw_mid count=%0d ack/val=%b dout=%h want 5/11/0064",
                     bus.data_count, {bus.wr_ack, bus.valid}, bus.dout);
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b1, 16'h0000);
            checks++;
            if (bus.dout !== exp_dout || bus.data_count !== 16'(exp_count)) begin
                errors++;
                $display("FAIL rw_mid_drain%0d dout=%h count=%0d want %h/%0d",
                         i, bus.dout, bus.data_count, exp_dout, exp_count);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, 16'(i * 3 + 7) ^ 16'h8000);
            checks++;
            if (bus.data_count !== 16'(i + 1) || bus.almost_full !== ((i + 1) >= DEPTH - 1) ||
                bus.full !== ((i + 1) == DEPTH)) begin
                errors++;
                $display("FAIL fill%0d count=%0d af=%b full=%b", i, bus.data_count, bus.almost_full, bus.full);
            end
        end
        do_cycle(1'b1, 1'b0, 16'hffff);
        checks++;
        if ({bus.overflow, bus.wr_ack, bus.full} !== 3'b101 || bus.data_count !== 16'd8192) begin
            errors++;
            $display("FAIL overflow ovf/ack/full=%b count=%0d want 101/8192",
                     {bus.overflow, bus.wr_ack, bus.full}, bus.data_count);
        end
        do_cycle(1'b1, 1'b1, 16'hdead);
        checks++;
        if (bus.data_count !== 16'd8191 || {bus.overflow, bus.valid} !== 2'b11 || bus.dout !== 16'h8007) begin
            errors++;
            $display("FAIL rw_full count=%0d ovf/val=%b dout=%h want 8191/11/8007",
                     bus.data_count, {bus.overflow, bus.valid}, bus.dout);
        end
        for (int i = 1; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 16'h0000);
            checks++;
            if (bus.dout !== (16'(i * 3 + 7) ^ 16'h8000) || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL drain%0d dout=%h valid=%b want %h/1",
                         i, bus.dout, bus.valid, 16'(i * 3 + 7) ^ 16'h8000);
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.data_count !== 16'd0) begin
            errors++;
            $display("FAIL drain_end empty=%b count=%0d want 1/0", bus.empty, bus.data_count);
        end
    endtask

    task automatic test_wrap();
        do_cycle(1'b1, 1'b0, 16'd0);
        for (int i = 1; i < 20000; i++) begin
            do_cycle(1'b1, 1'b1, 16'(i));
            checks++;
            if (bus.dout !== 16'(i - 1) || bus.data_count !== 16'd1 ||
                {bus.wr_ack, bus.overflow, bus.underflow, bus.valid} !== 4'b1001) begin
                errors++;
                $display("FAIL wrap%0d dout=%h count=%0d ack/ovf/udf/val=%b want %h/1/1001", i,
                         bus.dout, bus.data_count, {bus.wr_ack, bus.overflow, bus.underflow, bus.valid},
                         16'(i - 1));
            end
        end
        do_cycle(1'b0, 1'b1, 16'h0000);
        checks++;
        if (bus.dout !== 16'd19999 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_last dout=%0d empty=%b want 19999/1", bus.dout, bus.empty);
        end
    endtask

    initial begin
        bus.din   = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_underflow();
        test_simul_mid();
        test_full();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
